// File: rtl/shift_register_pkg.sv
// Shared encodings for the parameterised shift register: operation modes and FSM states.
package shift_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ASR  = 3'b101
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational one-step shifter used by both manual Mode operations and automatic runs.
module shift_step_unit
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       mode,
    input  logic [STEP-1:0]  ser_in,
    output logic [WIDTH-1:0] next_data,
    output logic [STEP-1:0]  disp,
    output logic             shifted
);

    always_comb begin
        next_data = data;
        disp      = '0;
        shifted   = 1'b1;
        case (mode)
            MODE_SHL: begin
                next_data = {data[WIDTH-STEP-1:0], ser_in};
                disp      = data[WIDTH-1 -: STEP];
            end
            MODE_SHR: begin
                next_data = {ser_in, data[WIDTH-1:STEP]};
                disp      = data[STEP-1:0];
            end
            MODE_ROL: begin
                next_data = {data[WIDTH-STEP-1:0], data[WIDTH-1 -: STEP]};
                disp      = data[WIDTH-1 -: STEP];
            end
            MODE_ROR: begin
                next_data = {data[STEP-1:0], data[WIDTH-1:STEP]};
                disp      = data[STEP-1:0];
            end
            MODE_ASR: begin
                next_data = {{STEP{data[WIDTH-1]}}, data[WIDTH-1:STEP]};
                disp      = data[STEP-1:0];
            end
            // HOLD and the unused encodings leave the register and SerOut untouched
            default: shifted = 1'b0;
        endcase
    end

endmodule

// File: rtl/shift_register_param.sv
// Parameterised shift register with manual per-edge operations and counted automatic runs.
//   state   | meaning
//   IDLE    | Mode applied every enabled edge; Start latches Mode/Count
//   RUN     | latched Mode applied each enabled edge, counter decrements
//   DONE    | one-cycle Done pulse, then back to IDLE
module shift_register_param
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEP  = 4,
    localparam int CNT_W = $clog2(WIDTH / STEP) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       mode,
    input  logic [STEP-1:0]  ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] out,
    output logic [STEP-1:0]  ser_out,
    output logic             busy,
    output logic             done
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       run_mode, run_mode_next;
    logic [WIDTH-1:0] data_q, data_next;
    logic [STEP-1:0]  ser_q, ser_next;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_data;
    logic [STEP-1:0]  step_disp;
    logic             step_shifted;

    // One shifter serves both paths; the run path ignores the live Mode input
    assign step_mode = (state == ST_RUN) ? run_mode : mode;

    shift_step_unit #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) u_step (
        .data     (data_q),
        .mode     (step_mode),
        .ser_in   (ser_in),
        .next_data(step_data),
        .disp     (step_disp),
        .shifted  (step_shifted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            run_mode <= MODE_HOLD;
            data_q   <= '0;
            ser_q    <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            run_mode <= run_mode_next;
            data_q   <= data_next;
            ser_q    <= ser_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        run_mode_next = run_mode;
        data_next     = data_q;
        ser_next      = ser_q;
        if (en) begin
            if (load) begin
                data_next  = in;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            run_mode_next = mode;
                            cnt_next      = count;
                            state_next    = (count != '0) ? ST_RUN : ST_DONE;
                        end else begin
                            data_next = step_data;
                            if (step_shifted) ser_next = step_disp;
                        end
                    end
                    ST_RUN: begin
                        data_next = step_data;
                        if (step_shifted) ser_next = step_disp;
                        cnt_next = cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state_next = ST_DONE;
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    assign out     = data_q;
    assign ser_out = ser_q;
    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_shift_register_param.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_shift_register_param;

    localparam int W = 64;
    localparam int S = 4;
    localparam int CW = $clog2(W / S) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          en, load, start;
    logic [W-1:0]  in;
    logic [2:0]    mode;
    logic [S-1:0]  ser_in;
    logic [CW-1:0] count;
    logic [W-1:0]  out;
    logic [S-1:0]  ser_out;
    logic          busy, done;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    shift_register_param #(.WIDTH(W), .STEP(S)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .in(in), .mode(mode),
        .ser_in(ser_in), .start(start), .count(count), .out(out),
        .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 running, 2 done
    logic [W-1:0] m_out;
    logic [S-1:0] m_ser;
    int           m_phase;
    int           m_left;
    int           m_mode;

    function automatic logic [W-1:0] op_out(int md, logic [W-1:0] v, logic [S-1:0] s);
        logic [W-1:0] sx;
        sx = W'(s);
        case (md)
            1: return (v << S) | sx;
            2: return (v >> S) | (sx << (W - S));
            3: return (v << S) | (v >> (W - S));
            4: return (v >> S) | (v << (W - S));
            5: return W'($signed(v) >>> S);
            default: return v;
        endcase
    endfunction

    function automatic logic [S-1:0] op_ser(int md, logic [W-1:0] v, logic [S-1:0] old);
        case (md)
            1, 3: return S'(v >> (W - S));
            2, 4, 5: return S'(v);
            default: return old;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_out <= '0; m_ser <= '0; m_phase <= 0; m_left <= 0; m_mode <= 0;
        end else if (en) begin
            if (load) begin
                m_out <= in; m_phase <= 0;
            end else if (m_phase == 0) begin
                if (start) begin
                    m_mode  <= int'(mode);
                    m_left  <= int'(count);
                    m_phase <= (count == 0) ? 2 : 1;
                end else begin
                    m_out <= op_out(int'(mode), m_out, ser_in);
                    m_ser <= op_ser(int'(mode), m_out, m_ser);
                end
            end else if (m_phase == 1) begin
                m_out  <= op_out(m_mode, m_out, ser_in);
                m_ser  <= op_ser(m_mode, m_out, m_ser);
                m_left <= m_left - 1;
                if (m_left == 1) m_phase <= 2;
            end else begin
                m_phase <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("out", out, m_out);
            check("ser_out", W'(ser_out), W'(m_ser));
            check("busy", W'(busy), W'(m_phase == 1));
            check("done", W'(done), W'(m_phase == 2));
        end
    end

    task automatic drive(input logic e, input logic l, input logic [W-1:0] d,
                         input logic [2:0] m, input logic [S-1:0] s,
                         input logic st, input logic [CW-1:0] c);
        en = e; load = l; in = d; mode = m; ser_in = s; start = st; count = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 0; load = 0; in = '0; mode = 0; ser_in = 0; start = 0; count = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", out, 64'h0);
        check("reset_busy", W'(busy), 64'h0);
        reset = 1'b0;
        cmp_on = 1'b1;

        // Load then 15 left shifts with zero fill
        drive(1, 1, 64'h55, 3'd0, 4'h0, 0, 0);
        repeat (15) drive(1, 0, '0, 3'd1, 4'h0, 0, 0);
        check("shl_out", out, 64'h5000000000000000);
        check("shl_ser", W'(ser_out), 64'h5);
        check("shl_model", m_out, 64'h5000000000000000);

        drive(1, 1, 64'h0123456789ABCDEF, 3'd0, 4'h0, 0, 0);
        drive(1, 0, '0, 3'd4, 4'h0, 0, 0);
        check("ror_out", out, 64'hF0123456789ABCDE);
        check("ror_ser", W'(ser_out), 64'hF);
        check("ror_model", m_out, 64'hF0123456789ABCDE);

        drive(1, 1, 64'h8000000000000000, 3'd0, 4'h0, 0, 0);
        drive(1, 0, '0, 3'd5, 4'h0, 0, 0);
        check("asr_out", out, 64'hF800000000000000);
        check("asr_model", m_out, 64'hF800000000000000);

        // Run of 3; Mode and Start during the run are ignored
        drive(1, 1, 64'h1, 3'd0, 4'h0, 0, 0);
        drive(1, 0, '0, 3'd1, 4'h0, 1, 5'd3);
        check("run3_busy0", W'(busy), 64'h1);
        check("run3_out0", out, 64'h1);
        drive(1, 0, '0, 3'd4, 4'h0, 1, 5'd7);
        check("run3_busy1", W'(busy), 64'h1);
        drive(1, 0, '0, 3'd4, 4'h0, 1, 5'd7);
        check("run3_busy2", W'(busy), 64'h1);
        drive(1, 0, '0, 3'd0, 4'h0, 0, 0);
        check("run3_done", W'(done), 64'h1);
        check("run3_busy_end", W'(busy), 64'h0);
        check("run3_out", out, 64'h1000);
        drive(1, 0, '0, 3'd1, 4'h0, 1, 5'd2);
        check("run3_idle_done", W'(done), 64'h0);
        check("run3_idle_busy", W'(busy), 64'h0);
        check("run3_idle_out", out, 64'h1000);

        // Count of zero goes straight to DONE
        drive(1, 0, '0, 3'd1, 4'h0, 1, 5'd0);
        check("cnt0_done", W'(done), 64'h1);
        check("cnt0_out", out, 64'h1000);
        drive(1, 0, '0, 3'd0, 4'h0, 0, 0);
        check("cnt0_idle", W'(done), 64'h0);

        // Run of 5 with En dropped for two cycles
        drive(1, 1, 64'h1, 3'd0, 4'h0, 0, 0);
        drive(1, 0, '0, 3'd1, 4'h0, 1, 5'd5);
        repeat (2) drive(1, 0, '0, 3'd0, 4'h0, 0, 0);
        check("frz_before", out, 64'h100);
        repeat (2) drive(0, 1, 64'hDEAD, 3'd2, 4'h0, 1, 5'd1);
        check("frz_out", out, 64'h100);
        check("frz_busy", W'(busy), 64'h1);
        repeat (3) drive(1, 0, '0, 3'd0, 4'h0, 0, 0);
        check("frz_done", W'(done), 64'h1);
        check("frz_result", out, 64'h100000);
        drive(1, 0, '0, 3'd0, 4'h0, 0, 0);

        // Load aborts a run without Done
        drive(1, 0, '0, 3'd1, 4'h0, 1, 5'd5);
        repeat (2) drive(1, 0, '0, 3'd0, 4'h0, 0, 0);
        drive(1, 1, 64'hABC, 3'd0, 4'h0, 0, 0);
        check("abort_busy", W'(busy), 64'h0);
        check("abort_done", W'(done), 64'h0);
        check("abort_out", out, 64'hABC);
        repeat (4) begin
            drive(1, 0, '0, 3'd0, 4'h0, 0, 0);
            check("abort_no_done", W'(done), 64'h0);
        end

        // Asynchronous reset between edges during a run
        drive(1, 0, '0, 3'd3, 4'h0, 1, 5'd5);
        drive(1, 0, '0, 3'd0, 4'h0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("arst_out", out, 64'h0);
        check("arst_ser", W'(ser_out), 64'h0);
        check("arst_busy", W'(busy), 64'h0);
        check("arst_done", W'(done), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 0, '0, 3'd0, 4'h0, 0, 0);
        check("arst_idle_busy", W'(busy), 64'h0);
        check("arst_idle_done", W'(done), 64'h0);
        check("arst_idle_out", out, 64'h0);

        // Random traffic, checked every cycle by the compare process
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0),
                  {$urandom, $urandom}, 3'($urandom_range(0, 7)), 4'($urandom),
                  ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 20)));
        end

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
